// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA block-copy engine.
package dma_pkg;

  localparam int unsigned DMA_DATA_W = 32;
  localparam int unsigned DMA_ADDR_W = 16;

  // Idle (DMAEn=0) cycles inserted after every accepted access, so a
  // duplicate service of the still-held request lands where Valid is ignored.
  localparam int unsigned TURN_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_TURN,
    WR,
    WR_TURN,
    FIN
  } dma_state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Requester-side view of the memory_controller DMA port.
interface dma_copy_engine_if
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMA_DATA_W,
  parameter int unsigned ADDR_WIDTH = DMA_ADDR_W
);

  logic                  DMAEn;
  logic                  DMAWrEn;
  logic [ADDR_WIDTH-1:0] DMAAddr;
  logic [DATA_WIDTH-1:0] DMAData;
  logic [DATA_WIDTH-1:0] DMAOut;
  logic                  DMAValid;

  modport master (
    output DMAEn, DMAWrEn, DMAAddr, DMAData,
    input  DMAOut, DMAValid
  );

  modport slave (
    input  DMAEn, DMAWrEn, DMAAddr, DMAData,
    output DMAOut, DMAValid
  );

endinterface

// File: rtl/dma_copy_engine.sv
// Block-copy initiator: reads Len words from SrcAddr and writes them in
// ascending order to DstAddr through the memory_controller DMA port.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMA_DATA_W,
  parameter int unsigned ADDR_WIDTH = DMA_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] SrcAddr,
  input  logic [ADDR_WIDTH-1:0] DstAddr,
  input  logic [ADDR_WIDTH-1:0] Len,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Aborted,
  output logic [ADDR_WIDTH-1:0] Count,
  dma_copy_engine_if.master     bus
);

  localparam int unsigned TURN_CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  dma_state_t            state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  abort_q;
  logic [TURN_CW-1:0]    turn_cnt;
  logic                  turn_last;

  assign turn_last = (turn_cnt == TURN_CW'(TURN_CYCLES - 1));

  // Requests are registered and held until DMAValid; async reset drops DMAEn at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      buf_q       <= '0;
      abort_q     <= 1'b0;
      turn_cnt    <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Aborted     <= 1'b0;
      Count       <= '0;
      bus.DMAEn   <= 1'b0;
      bus.DMAWrEn <= 1'b0;
      bus.DMAAddr <= '0;
      bus.DMAData <= '0;
    end else begin
      Done    <= 1'b0;
      Aborted <= 1'b0;

      case (state)
        IDLE: begin
          // Abort beats a simultaneous Start: nothing begins, no Done.
          if (Start && !Abort) begin
            src_q    <= SrcAddr;
            dst_q    <= DstAddr;
            len_q    <= Len;
            Count    <= '0;
            abort_q  <= 1'b0;
            turn_cnt <= '0;
            Busy     <= 1'b1;
            if (Len == '0) begin
              state <= FIN;
            end else begin
              bus.DMAEn   <= 1'b1;
              bus.DMAWrEn <= 1'b0;
              bus.DMAAddr <= SrcAddr;
              state       <= RD;
            end
          end
        end

        RD: begin
          if (Abort) begin
            bus.DMAEn <= 1'b0;
            abort_q   <= 1'b1;
            state     <= FIN;
          end else if (bus.DMAValid) begin
            buf_q     <= bus.DMAOut;
            bus.DMAEn <= 1'b0;
            state     <= RD_TURN;
          end
        end

        RD_TURN: begin
          if (Abort) begin
            abort_q  <= 1'b1;
            turn_cnt <= '0;
            state    <= FIN;
          end else if (!turn_last) begin
            turn_cnt <= turn_cnt + TURN_CW'(1);
          end else begin
            turn_cnt    <= '0;
            bus.DMAEn   <= 1'b1;
            bus.DMAWrEn <= 1'b1;
            bus.DMAAddr <= dst_q + Count;
            bus.DMAData <= buf_q;
            state       <= WR;
          end
        end

        WR: begin
          // An acknowledged write counts even when Abort arrives on the same edge.
          if (bus.DMAValid) begin
            Count <= Count + ADDR_WIDTH'(1);
          end
          if (Abort) begin
            bus.DMAEn <= 1'b0;
            abort_q   <= 1'b1;
            state     <= FIN;
          end else if (bus.DMAValid) begin
            bus.DMAEn <= 1'b0;
            state     <= WR_TURN;
          end
        end

        WR_TURN: begin
          if (Abort) begin
            abort_q  <= 1'b1;
            turn_cnt <= '0;
            state    <= FIN;
          end else if (!turn_last) begin
            turn_cnt <= turn_cnt + TURN_CW'(1);
          end else begin
            turn_cnt <= '0;
            if (Count == len_q) begin
              state <= FIN;
            end else begin
              bus.DMAEn   <= 1'b1;
              bus.DMAWrEn <= 1'b0;
              bus.DMAAddr <= src_q + Count;
              state       <= RD;
            end
          end
        end

        FIN: begin
          Done    <= 1'b1;
          Aborted <= abort_q;
          Busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          bus.DMAEn <= 1'b0;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: ideal memory controller with CPU contention,
// ascending-copy memory model, directed and random copies.
module tb_dma_copy_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic [AW-1:0] SrcAddr = '0;
  logic [AW-1:0] DstAddr = '0;
  logic [AW-1:0] Len = '0;
  logic          Busy;
  logic          Done;
  logic          Aborted;
  logic [AW-1:0] Count;

  dma_copy_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dma_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .Abort   (Abort),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Len     (Len),
    .Busy    (Busy),
    .Done    (Done),
    .Aborted (Aborted),
    .Count   (Count),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [65536];
  logic [DW-1:0] exp_mem [65536];
  logic [AW:0]   log_q [$];
  logic          cpu_hold = 1'b0;
  int            cyc = 0;
  int            en_cycles = 0;
  int            errors = 0;
  int            checks = 0;
  int            start_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.DMAEn) en_cycles <= en_cycles + 1;
  end

  // Memory controller: services DMA when the CPU is not holding the port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.DMAValid <= 1'b0;
      bus.DMAOut   <= '0;
    end else if (bus.DMAEn && !cpu_hold) begin
      if (!bus.DMAValid) log_q.push_back({bus.DMAWrEn, bus.DMAAddr});
      if (bus.DMAWrEn) mem[bus.DMAAddr] = bus.DMAData;
      else             bus.DMAOut <= mem[bus.DMAAddr];
      bus.DMAValid <= 1'b1;
    end else begin
      bus.DMAValid <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW-1:0] l, input logic ab);
    @(negedge clk);
    SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1; Abort = ab;
    @(negedge clk);
    Start = 1'b0; Abort = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int bound, output int lat);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done seen"}, 64'(Done), 64'(1));
    lat = cyc - start_cyc;
  endtask

  // Reference: strictly ascending word copy with 16-bit address wrap.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    for (int i = 0; i < int'(l); i++) begin
      a = s + AW'(i);
      b = d + AW'(i);
      exp_mem[b] = exp_mem[a];
    end
  endtask

  task automatic check_mem(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check(tag, 64'(diffs), 64'(0));
  endtask

  task automatic run_copy(input string tag, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input logic [AW-1:0] l);
    int lat;
    int en0;
    en0 = en_cycles;
    pulse_start(s, d, l, 1'b0);
    wait_done(tag, 6 * int'(l) + 200, lat);
    check({tag, " latency"}, 64'(lat), 64'(6 * int'(l) + 1));
    check({tag, " count"}, 64'(Count), 64'(l));
    check({tag, " aborted"}, 64'(Aborted), 64'(0));
    @(negedge clk);
    check({tag, " done pulse"}, 64'(Done), 64'(0));
    check({tag, " count hold"}, 64'(Count), 64'(l));
    check({tag, " en cycles"}, 64'(en_cycles - en0), 64'(4 * int'(l)));
    model_copy(s, d, l);
    check_mem({tag, " mem"});
  endtask

  initial begin
    int            lat;
    int            n;
    int            a;
    int            en1;
    logic          stable;
    logic          seen_busy;
    logic          seen_done;
    logic [DW-1:0] v;
    logic [AW:0]   wexp [6];
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    logic [AW-1:0] rl;

    #1 rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + i] = 32'hA0 + DW'(i);
      exp_mem[16'h0100 + i] = mem[16'h0100 + i];
    end
    repeat (3) @(negedge clk);
    check("reset busy", 64'(Busy), 64'(0));
    check("reset done", 64'(Done), 64'(0));
    check("reset aborted", 64'(Aborted), 64'(0));
    check("reset count", 64'(Count), 64'(0));
    check("reset dmaen", 64'(bus.DMAEn), 64'(0));
    check("reset dmaaddr", 64'(bus.DMAAddr), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    // Ideal four-word copy and empty copy
    run_copy("ideal", 16'h0100, 16'h0200, 16'd4);
    check("ideal word3", 64'(mem[16'h0203]), 64'(32'hA3));
    run_copy("len0", 16'h0123, 16'h0456, 16'd0);

    // Address wrap on both source and destination
    log_q.delete();
    run_copy("wrap", 16'hFFFE, 16'h7FFF, 16'd3);
    wexp = '{17'h0FFFE, 17'h17FFF, 17'h0FFFF, 17'h18000, 17'h00000, 17'h18001};
    check("wrap access count", 64'(log_q.size()), 64'(6));
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check($sformatf("wrap access %0d", i), 64'(log_q[i]), 64'(wexp[i]));

    // Overlapping regions replicate the source pattern
    v = exp_mem[16'h0900];
    run_copy("overlap", 16'h0900, 16'h0901, 16'd5);
    check("overlap replicate", 64'(mem[16'h0905]), 64'(v));

    // CPU holds the port for 10 cycles during the read of word 1; a Start mid-copy is ignored
    pulse_start(16'h0500, 16'h0600, 16'd4, 1'b0);
    n = 0;
    while (!(bus.DMAEn === 1'b1 && bus.DMAWrEn === 1'b0 && bus.DMAAddr === 16'h0501) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cont reach word1", 64'(n < 100), 64'(1));
    cpu_hold = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(bus.DMAEn === 1'b1 && bus.DMAWrEn === 1'b0 && bus.DMAAddr === 16'h0501)) stable = 1'b0;
      if (i == 3) begin
        SrcAddr = 16'h0ABC; DstAddr = 16'h0CDE; Len = 16'd2; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    cpu_hold = 1'b0;
    check("cont hold stable", 64'(stable), 64'(1));
    wait_done("cont", 400, lat);
    check("cont latency", 64'(lat), 64'(35));
    check("cont count", 64'(Count), 64'(4));
    check("cont aborted", 64'(Aborted), 64'(0));
    model_copy(16'h0500, 16'h0600, 16'd4);
    check_mem("cont mem");

    // Abort during the write of word 2 of an 8-word copy
    pulse_start(16'h0A00, 16'h0B00, 16'd8, 1'b0);
    n = 0;
    while (!(bus.DMAEn === 1'b1 && bus.DMAWrEn === 1'b1 && bus.DMAAddr === 16'h0B02) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort reach wr2", 64'(n < 200), 64'(1));
    Abort = 1'b1;
    a = cyc;
    @(negedge clk);
    Abort = 1'b0;
    en1 = en_cycles;
    wait_done("abort", 10, lat);
    check("abort within 2", 64'((cyc - a) <= 2), 64'(1));
    check("abort flag", 64'(Aborted), 64'(1));
    check("abort count", 64'(Count), 64'(2));
    repeat (4) @(negedge clk);
    check("abort no en", 64'(en_cycles - en1), 64'(0));
    check("abort flag clears", 64'(Aborted), 64'(0));
    model_copy(16'h0A00, 16'h0B00, 16'd2);
    exp_mem[16'h0B02] = mem[16'h0B02];
    check_mem("abort mem");
    run_copy("after abort", 16'h0A00, 16'h0B00, 16'd8);

    // Start together with Abort in IDLE does nothing
    pulse_start(16'h0C00, 16'h0D00, 16'd3, 1'b1);
    seen_busy = Busy;
    seen_done = Done;
    repeat (8) begin
      @(negedge clk);
      seen_busy |= Busy;
      seen_done |= Done;
    end
    check("start+abort busy", 64'(seen_busy), 64'(0));
    check("start+abort done", 64'(seen_done), 64'(0));
    check("start+abort count", 64'(Count), 64'(8));
    check_mem("start+abort mem");

    // Asynchronous reset during a read
    pulse_start(16'h0E00, 16'h0F00, 16'd4, 1'b0);
    check("rst in rd", 64'(bus.DMAEn === 1'b1 && bus.DMAWrEn === 1'b0), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("rst dmaen async", 64'(bus.DMAEn), 64'(0));
    check("rst busy async", 64'(Busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst count", 64'(Count), 64'(0));
    check_mem("rst mem");
    run_copy("after reset", 16'h0E00, 16'h0F00, 16'd4);

    // Random copies, possibly overlapping or wrapping
    for (int k = 0; k < 4; k++) begin
      rs = AW'($urandom);
      rd = AW'($urandom);
      rl = AW'($urandom_range(1, 10));
      run_copy($sformatf("rand%0d", k), rs, rd, rl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Block-copy initiator that drives the DMA port of memory_controller (DMAEn/DMAWrEn/DMAAddr/DMAData in, DMAOut/DMAValid back).
- Software programs a source address, destination address and length, then pulses Start. The engine reads each word, writes it back at the destination, and signals Done.
- It is the requester end of the memory_controller DMA interface.

Parameters:
- DATA_WIDTH, 32, memory word width; must match memory_controller.
- ADDR_WIDTH, 16, word-address width; also the width of the length and count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  one-cycle pulse, sampled in IDLE only.
- Abort  in  1  synchronous cancel, sampled every cycle.
- SrcAddr  in  ADDR_WIDTH  first source word address, captured on Start.
- DstAddr  in  ADDR_WIDTH  first destination word address, captured on Start.
- Len  in  ADDR_WIDTH  number of words to copy, captured on Start.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a copy completes or is aborted.
- Aborted  out  1  qualifies Done: high only in the Done cycle of an aborted copy.
- Count  out  ADDR_WIDTH  words fully written so far; holds its value after Done until the next Start.
- DMAEn  out  1  request to the controller.
- DMAWrEn  out  1  1 = write, 0 = read.
- DMAAddr  out  ADDR_WIDTH  request address.
- DMAData  out  DATA_WIDTH  write data.
- DMAOut  in  DATA_WIDTH  read data; valid when DMAValid=1.
- DMAValid  in  1  controller has serviced the DMA request presented in the previous cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, internal src/dst/len/buffer registers 0. Reset mid-copy drops the request immediately, since DMAEn is cleared asynchronously.
- Bus rule: a request is held stable (DMAEn, DMAWrEn, DMAAddr, DMAData) until DMAValid is sampled 1 at a rising edge.
  - Arbitration loss (CPU or Acl has priority) just extends the hold.
- Every accepted access is followed by exactly one TURN cycle with DMAEn=0. DMAValid in a TURN cycle is ignored.
  - Reason: the controller may service the still-held request a second time in the Valid cycle; that duplicate is idempotent (same address/data) and its Valid lands in TURN.
- State machine: IDLE, RD, RD_TURN, WR, WR_TURN, FIN.
  - IDLE: on Start, capture SrcAddr/DstAddr/Len, clear Count. Go to FIN if Len==0, else RD.
  - RD: DMAEn=1, DMAWrEn=0, DMAAddr=src+Count. On DMAValid, capture DMAOut into buffer and go to RD_TURN.
  - RD_TURN: go to WR.
  - WR: DMAEn=1, DMAWrEn=1, DMAAddr=dst+Count, DMAData=buffer. On DMAValid, Count+1 and go to WR_TURN.
  - WR_TURN: go to FIN if Count==Len, else RD.
  - FIN: Done=1 for one cycle, then IDLE.
- Address arithmetic: src+Count and dst+Count are computed modulo 2^ADDR_WIDTH, so 0xFFFF+1 wraps to 0x0000.
- Len=0xFFFF is legal; Count reaches 0xFFFF without overflow.
- Minimum timing: 6 cycles per word. Done is asserted 6*Len+1 cycles after the Start edge with no contention, and 1 cycle after for Len=0.
- Overlap: copy order is strictly ascending. With dst in (src, src+Len) the source pattern is replicated, and this is the specified result.
- Start while Busy: ignored.
- Start and Abort together in IDLE: Abort wins; no copy starts and there is no Done.
- Abort while Busy:
  - In RD or WR, the request is dropped at the next edge.
  - Any in-flight write that already received DMAValid is counted; a pending unacknowledged write may or may not have reached memory.
  - The engine then goes to FIN with Aborted=1.

Decomposition:
- Package dma_pkg: state enum typedef (dma_state_t) and the TURN-cycle constant.
- Single module; no sub-module is warranted. The datapath is an address adder pair plus one buffer register.

Test Plan:
- Ideal controller (Valid one cycle after each En cycle): preload mem[0x0100..0x0103]=A0..A3, Src=0x0100, Dst=0x0200, Len=4 -> mem[0x0200..0x0203]=A0..A3, Done exactly 25 cycles after the Start edge, Count=4, Aborted=0.
- Len=0 -> Done on the next cycle, DMAEn never asserted, Count=0.
- Wrap: Src=0xFFFE, Dst=0x7FFF, Len=3 -> reads 0xFFFE, 0xFFFF, 0x0000; writes 0x7FFF, 0x8000, 0x8001.
- Contention: CPU continuously enabled for 10 cycles during the DMA read of word 1 -> DMA request held stable with no address change, copy completes correctly, Done delayed by 10 cycles.
- Abort asserted in WR of word 2 of Len=8 -> Done with Aborted=1 within 2 cycles, Count=2, no further DMAEn; a second Start then copies fully.
- Async reset asserted mid-RD -> DMAEn/Busy go 0 immediately without waiting for clk; after release the engine is in IDLE and accepts Start.
